// File: rtl/pc_sequencer.sv
// Multi-cycle control FSM for the RV32 program counter.
// Per instruction: fetch over a req/ack handshake, decode the opcode, start the datapath,
// wait for it to finish, then pulse pc_en with the matching pc_sel.
// Also covers ebreak/debug halt, a sticky fetch-timeout fault and a retired-instruction
// counter.
module pc_sequencer #(
    parameter int unsigned FETCH_TIMEOUT = 15,
    parameter int unsigned RET_W         = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run,
    output logic             imem_req,
    input  logic             imem_ack,
    input  logic [31:0]      imem_rdata,
    output logic [31:0]      instr_q,
    output logic             ex_start,
    input  logic             ex_done,
    input  logic             branch_taken,
    input  logic             halt_req,
    input  logic             resume,
    output logic             pc_en,
    output logic [1:0]       pc_sel,
    output logic             halted,
    output logic             fault,
    output logic [RET_W-1:0] retired
);

    localparam int unsigned CntW = $clog2(FETCH_TIMEOUT + 1);
    localparam logic [CntW-1:0] CntLast = CntW'(FETCH_TIMEOUT - 1);

    localparam logic [31:0] InstrEbreak = 32'h0010_0073;
    localparam logic [6:0]  OpJal       = 7'b1101111;
    localparam logic [6:0]  OpJalr      = 7'b1100111;
    localparam logic [6:0]  OpBranch    = 7'b1100011;

    localparam logic [1:0] SelPc4  = 2'b00;
    localparam logic [1:0] SelImm  = 2'b01;
    localparam logic [1:0] SelAlu  = 2'b10;
    localparam logic [1:0] SelHold = 2'b11;

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StDecode,
        StExec,
        StUpdate,
        StHalt
    } state_e;

    state_e            state_q, state_d;
    logic [31:0]       instr_d;
    logic [1:0]        sel_q, sel_d;
    logic              is_br_q, is_br_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              fault_q, fault_d;
    logic              ebrk_q, ebrk_d;
    logic              halt_pend_q, halt_pend_d;
    logic [RET_W-1:0]  retired_q, retired_d;
    logic              ex_start_q, ex_start_d;

    // State and datapath registers; reset aborts any instruction in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            instr_q     <= 32'h0;
            sel_q       <= SelPc4;
            is_br_q     <= 1'b0;
            cnt_q       <= '0;
            fault_q     <= 1'b0;
            ebrk_q      <= 1'b0;
            halt_pend_q <= 1'b0;
            retired_q   <= '0;
            ex_start_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            instr_q     <= instr_d;
            sel_q       <= sel_d;
            is_br_q     <= is_br_d;
            cnt_q       <= cnt_d;
            fault_q     <= fault_d;
            ebrk_q      <= ebrk_d;
            halt_pend_q <= halt_pend_d;
            retired_q   <= retired_d;
            ex_start_q  <= ex_start_d;
        end
    end

    // Next-state logic: sequencing, opcode classification, timeout and halt handling.
    always_comb begin
        state_d     = state_q;
        instr_d     = instr_q;
        sel_d       = sel_q;
        is_br_d     = is_br_q;
        cnt_d       = cnt_q;
        fault_d     = fault_q;
        ebrk_d      = ebrk_q;
        halt_pend_d = halt_pend_q;
        retired_d   = retired_q;
        ex_start_d  = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (halt_req) begin
                    state_d = StHalt;
                    ebrk_d  = 1'b0;
                end else if (run) begin
                    state_d = StFetch;
                    cnt_d   = '0;
                end
            end

            StFetch: begin
                // A halt request here waits until the instruction has retired.
                if (halt_req) begin
                    halt_pend_d = 1'b1;
                end
                if (imem_ack) begin
                    instr_d = imem_rdata;
                    cnt_d   = '0;
                    state_d = StDecode;
                end else if (cnt_q == CntLast) begin
                    fault_d = 1'b1;
                    cnt_d   = '0;
                    ebrk_d  = 1'b0;
                    state_d = StHalt;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            StDecode: begin
                if (halt_req) begin
                    halt_pend_d = 1'b1;
                end
                if (instr_q == InstrEbreak) begin
                    // Resuming from ebreak retires it with a plain pc+4.
                    state_d = StHalt;
                    ebrk_d  = 1'b1;
                    sel_d   = SelPc4;
                    is_br_d = 1'b0;
                end else begin
                    state_d    = StExec;
                    ex_start_d = 1'b1;
                    is_br_d    = 1'b0;
                    unique case (instr_q[6:0])
                        OpJal:    sel_d = SelImm;
                        OpJalr:   sel_d = SelAlu;
                        OpBranch: begin
                            sel_d   = SelPc4;
                            is_br_d = 1'b1;
                        end
                        default:  sel_d = SelPc4;
                    endcase
                end
            end

            StExec: begin
                if (halt_req) begin
                    halt_pend_d = 1'b1;
                end
                if (ex_done) begin
                    if (is_br_q) begin
                        sel_d = branch_taken ? SelImm : SelPc4;
                    end
                    state_d = StUpdate;
                end
            end

            StUpdate: begin
                retired_d = retired_q + RET_W'(1);
                if (halt_req || halt_pend_q) begin
                    state_d = StHalt;
                    ebrk_d  = 1'b0;
                end else if (run) begin
                    state_d = StFetch;
                    cnt_d   = '0;
                end else begin
                    state_d = StIdle;
                end
            end

            StHalt: begin
                // A fault is sticky: only reset leaves HALT after a fetch timeout.
                if (resume && !fault_q) begin
                    if (ebrk_q) begin
                        state_d = StUpdate;
                        sel_d   = SelPc4;
                    end else begin
                        state_d = StFetch;
                        cnt_d   = '0;
                    end
                    ebrk_d = 1'b0;
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase

        // Any pending halt is consumed once HALT is reached.
        if (state_d == StHalt) begin
            halt_pend_d = 1'b0;
        end
    end

    // Outputs decoded from state; pc_sel holds except during UPDATE.
    always_comb begin
        imem_req = (state_q == StFetch);
        pc_en    = (state_q == StUpdate);
        pc_sel   = (state_q == StUpdate) ? sel_q : SelHold;
        halted   = (state_q == StHalt);
        ex_start = ex_start_q;
        fault    = fault_q;
        retired  = retired_q;
    end

endmodule
